// File: rtl/sequenciador_ordena_if.sv
// Word stream bundle for the sorter: input side and output side.
// slave = sorter view, master = source/sink view.
interface sequenciador_ordena_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/sequenciador_ordena.sv
// Block bubble sorter driving an external compare/swap unit.
// Optional EARLY_EXIT_EN: leave SORT after a pass with no swaps.
module sequenciador_ordena #(
  parameter  int WIDTH = 9,
  parameter  int N     = 8,
  localparam int SW    = $clog2(N*(N-1)/2+1),
  localparam int IW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  sequenciador_ordena_if.slave bus,
  output logic              cs_ena,
  output logic [WIDTH-1:0]  cs_a,
  output logic [WIDTH-1:0]  cs_b,
  input  logic [WIDTH-1:0]  cs_lo,
  input  logic [WIDTH-1:0]  cs_hi,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     swap_count
);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bank [N];
  logic [IW-1:0]    wr_ptr;
  logic [IW-1:0]    rd_ptr;
  logic [IW-1:0]    i;
  logic [IW-1:0]    pass;
  logic [IW-1:0]    i_nx;
  logic [IW-1:0]    i_last;
  logic             swapped;
  logic             pass_end;
  logic             last_pass;
`ifdef EARLY_EXIT_EN
  logic             pass_swap;
`endif

  assign i_nx      = i + IW'(1);
  assign i_last    = IW'(N-2) - pass;
  assign pass_end  = (i == i_last);
  assign last_pass = (pass == IW'(N-2));
  assign swapped   = (cs_lo != cs_a);

  assign cs_ena        = (state == SORT);
  assign cs_a          = cs_ena ? bank[i] : '0;
  assign cs_b          = cs_ena ? bank[i_nx] : '0;
  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = bus.out_valid ? bank[rd_ptr] : '0;
  assign busy          = (state != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      i          <= '0;
      pass       <= '0;
      done       <= 1'b0;
      swap_count <= '0;
`ifdef EARLY_EXIT_EN
      pass_swap  <= 1'b0;
`endif
      for (int k = 0; k < N; k++) begin
        bank[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == LOAD): begin
          if (bus.in_valid) begin
            bank[wr_ptr] <= bus.in_data;
            if (wr_ptr == IW'(N-1)) begin
              wr_ptr     <= '0;
              pass       <= '0;
              i          <= '0;
              swap_count <= '0;
`ifdef EARLY_EXIT_EN
              pass_swap  <= 1'b0;
`endif
              state      <= SORT;
            end else begin
              wr_ptr <= wr_ptr + IW'(1);
            end
          end
        end
        (state == SORT): begin
          bank[i]    <= cs_lo;
          bank[i_nx] <= cs_hi;
          if (swapped) begin
            swap_count <= swap_count + SW'(1);
          end
          if (pass_end) begin
            i    <= '0;
            pass <= pass + IW'(1);
`ifdef EARLY_EXIT_EN
            pass_swap <= 1'b0;
            if (last_pass || !(pass_swap || swapped)) begin
              state <= DRAIN;
            end
`else
            if (last_pass) begin
              state <= DRAIN;
            end
`endif
          end else begin
            i <= i_nx;
`ifdef EARLY_EXIT_EN
            pass_swap <= pass_swap | swapped;
`endif
          end
        end
        (state == DRAIN): begin
          if (bus.out_ready) begin
            if (rd_ptr == IW'(N-1)) begin
              rd_ptr <= '0;
              done   <= 1'b1;
              state  <= LOAD;
            end else begin
              rd_ptr <= rd_ptr + IW'(1);
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
